// File: rtl/spk_in_demux.sv
// Node ingress demux: spike flits go to a FWFT FIFO for the axon, all other types become
// credit-flow-controlled write pulses to the config controller. Optional counters under SPK_IN_STAT_EN.
module spk_in_demux #(
    parameter int FW      = 59,
    parameter int FTW     = 3,
    parameter int SW      = 24,
    parameter int SPK_AW  = 3,
    parameter int CREDITS = 4,
    parameter int CNTW    = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_vld,
    input  logic [FW-1:0]   in_flit,
    output logic            in_rdy,
    output logic            spk_in_config_we,
    output logic [FW-1:0]   spk_in_config_wdata,
    input  logic            config_spk_in_credit,
    output logic            spk_axon_vld,
    output logic [SW-1:0]   spk_axon_neuid,
    input  logic            axon_spk_rdy,
    output logic            credit_err,
    output logic [CNTW-1:0] stat_spk_cnt,
    output logic [CNTW-1:0] stat_cfg_cnt
);

    localparam int         DEPTH    = 1 << SPK_AW;
    localparam logic [3:0] CRED_MAX = 4'(CREDITS);

    logic [SPK_AW:0] wptr_q, wptr_d;
    logic [SPK_AW:0] rptr_q, rptr_d;
    logic [SW-1:0]   mem_q [DEPTH];

    logic [3:0]      credit_q, credit_d;
    logic            credit_err_q, credit_err_d;
    logic            cfg_we_q, cfg_we_d;
    logic [FW-1:0]   cfg_wdata_q, cfg_wdata_d;

    logic            is_spk;
    logic            fifo_full;
    logic            fifo_empty;
    logic            spk_push;
    logic            spk_pop;
    logic            cfg_acc;

    always_comb begin
        is_spk     = (in_flit[FW-1 -: FTW] == '0);
        fifo_empty = (wptr_q == rptr_q);
        // Same slot index, different lap bit: writer is a full lap ahead.
        fifo_full  = (wptr_q[SPK_AW] != rptr_q[SPK_AW]) &&
                     (wptr_q[SPK_AW-1:0] == rptr_q[SPK_AW-1:0]);
        in_rdy     = is_spk ? !fifo_full : (credit_q != 4'd0);
        spk_push   = in_vld & in_rdy & is_spk;
        cfg_acc    = in_vld & in_rdy & ~is_spk;
        spk_pop    = ~fifo_empty & axon_spk_rdy;
    end

    always_comb begin
        wptr_d       = wptr_q + {{SPK_AW{1'b0}}, spk_push};
        rptr_d       = rptr_q + {{SPK_AW{1'b0}}, spk_pop};
        cfg_we_d     = cfg_acc;
        cfg_wdata_d  = cfg_acc ? in_flit : cfg_wdata_q;
        credit_d     = credit_q;
        credit_err_d = credit_err_q;
        case ({cfg_acc, config_spk_in_credit})
            2'b10: credit_d = credit_q - 4'd1;
            2'b01: begin
                // A returned credit beyond the initial grant is a protocol error; never overflow.
                if (credit_q == CRED_MAX) begin
                    credit_err_d = 1'b1;
                end else begin
                    credit_d = credit_q + 4'd1;
                end
            end
            default: credit_d = credit_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q       <= '0;
            rptr_q       <= '0;
            credit_q     <= CRED_MAX;
            credit_err_q <= 1'b0;
            cfg_we_q     <= 1'b0;
            cfg_wdata_q  <= '0;
        end else begin
            wptr_q       <= wptr_d;
            rptr_q       <= rptr_d;
            credit_q     <= credit_d;
            credit_err_q <= credit_err_d;
            cfg_we_q     <= cfg_we_d;
            cfg_wdata_q  <= cfg_wdata_d;
        end
    end

    // Storage needs no reset: pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (spk_push) begin
            mem_q[wptr_q[SPK_AW-1:0]] <= in_flit[SW-1:0];
        end
    end

    assign spk_axon_vld        = ~fifo_empty;
    assign spk_axon_neuid      = mem_q[rptr_q[SPK_AW-1:0]];
    assign spk_in_config_we    = cfg_we_q;
    assign spk_in_config_wdata = cfg_wdata_q;
    assign credit_err          = credit_err_q;

`ifdef SPK_IN_STAT_EN
    logic [CNTW-1:0] stat_spk_cnt_q, stat_spk_cnt_d;
    logic [CNTW-1:0] stat_cfg_cnt_q, stat_cfg_cnt_d;

    always_comb begin
        stat_spk_cnt_d = stat_spk_cnt_q + {{(CNTW-1){1'b0}}, spk_push};
        stat_cfg_cnt_d = stat_cfg_cnt_q + {{(CNTW-1){1'b0}}, cfg_acc};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_spk_cnt_q <= '0;
            stat_cfg_cnt_q <= '0;
        end else begin
            stat_spk_cnt_q <= stat_spk_cnt_d;
            stat_cfg_cnt_q <= stat_cfg_cnt_d;
        end
    end

    assign stat_spk_cnt = stat_spk_cnt_q;
    assign stat_cfg_cnt = stat_cfg_cnt_q;
`else
    assign stat_spk_cnt = '0;
    assign stat_cfg_cnt = '0;
`endif

endmodule
